// File: rtl/rd_rsp_encode_pkg.sv
// Shared definitions for the SDRAM read-response encoder: command bytes and FSM state encoding.
package rd_rsp_encode_pkg;

  localparam logic [7:0] RD_CMD8       = 8'h55;
  localparam int         BURST_LEN_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    POP     = 3'd2,
    LOAD    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } rsp_state_e;

endpackage

// File: rtl/rd_rsp_encode.sv
// Read-response encoder: pops one SDRAM read burst from rfifo and streams it byte-wise to UART_TX.
// Optional feature macro RSP_HEADER_EN prefixes each response with the RD_CMD8 header byte.
module rd_rsp_encode
  import rd_rsp_encode_pkg::*;
#(
  parameter int D_WIDTH   = 8,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_WIDTH = 3
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               rd_done,
  input  logic               rfifo_empty,
  output logic               rfifo_rd_en,
  input  logic [D_WIDTH-1:0] rfifo_data,
  output logic               tx_start,
  output logic [D_WIDTH-1:0] tx_data,
  input  logic               tx_busy,
  output logic               rsp_busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BURST_LEN - 1);

  rsp_state_e           state, state_nxt;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic                 pend;
  logic                 first_wait;
  logic                 start_req;
  logic                 data_phase;

  assign start_req = rd_done | pend;
  assign rsp_busy  = (state != IDLE);

`ifdef RSP_HEADER_EN
  logic hdr_phase;
  assign data_phase = ~hdr_phase;
`else
  assign data_phase = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    rfifo_rd_en = 1'b0;
    tx_start    = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
`ifdef RSP_HEADER_EN
          state_nxt = HDR;
`else
          state_nxt = POP;
`endif
        end
      end
      HDR:  state_nxt = SEND;
      POP: begin
        if (!rfifo_empty) begin
          rfifo_rd_en = 1'b1;
          state_nxt   = LOAD;
        end
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          state_nxt = WAIT_TX;
        end
      end
      WAIT_TX: begin
        // tx_busy only rises the cycle after tx_start, so the first cycle is skipped
        if (!first_wait && !tx_busy) begin
          if (data_phase && (word_cnt == LAST_CNT)) state_nxt = IDLE;
          else                                      state_nxt = POP;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (sys_rst) begin
      rfifo_rd_en = 1'b0;
      tx_start    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      pend       <= 1'b0;
      first_wait <= 1'b0;
      tx_data    <= '0;
`ifdef RSP_HEADER_EN
      hdr_phase  <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      first_wait <= tx_start;
      // a request arriving in the very cycle a pending one is consumed stays queued
      if (state == IDLE) begin
        if (start_req) begin
          pend     <= rd_done & pend;
          word_cnt <= '0;
        end
      end else if (rd_done) begin
        pend <= 1'b1;
      end
      case (state)
`ifdef RSP_HEADER_EN
        HDR: begin
          tx_data   <= D_WIDTH'(RD_CMD8);
          hdr_phase <= 1'b1;
        end
`endif
        LOAD: tx_data <= rfifo_data;
        WAIT_TX: begin
          if (!first_wait && !tx_busy) begin
            if (data_phase) word_cnt <= word_cnt + 1'b1;
`ifdef RSP_HEADER_EN
            hdr_phase <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_rsp_encode.sv
// Self-checking bench for rd_rsp_encode: rfifo and UART_TX models plus a byte-stream reference.
// Honours RSP_HEADER_EN the same way as the design.
module tb_rd_rsp_encode;

  localparam int BURST_LEN = 4;
`ifdef RSP_HEADER_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam int BPB = BURST_LEN + HDR_BYTES;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rd_done = 1'b0;
  logic       rfifo_empty = 1'b1;
  logic       rfifo_rd_en;
  logic [7:0] rfifo_data = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       rsp_busy;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int starts = 0;
  int tx_time = 10;
  int busy_cnt = 0;
  bit hold_chk = 1'b1;
  logic [7:0] last_sent = 8'h00;
  logic [7:0] fifo_q[$];
  logic [7:0] word_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  rd_rsp_encode dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rd_done    (rd_done),
    .rfifo_empty(rfifo_empty),
    .rfifo_rd_en(rfifo_rd_en),
    .rfifo_data (rfifo_data),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .rsp_busy   (rsp_busy)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Read FIFO model: data appears one cycle after the pop strobe.
  always @(posedge sys_clk) begin
    if (rfifo_rd_en) begin
      checkOutput("pop_while_empty", int'(rfifo_empty), 0);
      rfifo_data <= (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
      pops++;
    end
    rfifo_empty <= (fifo_q.size() == 0);
  end

  // UART_TX model: busy for tx_time cycles starting the cycle after tx_start.
  always @(posedge sys_clk) begin
    if (hold_chk && tx_busy) checkOutput("tx_data_hold", int'(tx_data), int'(last_sent));
    if (tx_start) begin
      checkOutput("start_while_busy", int'(tx_busy), 0);
      rx_q.push_back(tx_data);
      last_sent = tx_data;
      starts++;
      busy_cnt = tx_time;
      tx_busy <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt--;
    end else begin
      busy_cnt = 0;
      tx_busy <= 1'b0;
    end
  end

  task automatic applyStimulus(input logic [7:0] w);
    fifo_q.push_back(w);
    word_q.push_back(w);
  endtask

  // Reference: each response is an optional header then the next BURST_LEN fifo words in order.
  task automatic expectBursts(input int n);
    repeat (n) begin
`ifdef RSP_HEADER_EN
      exp_q.push_back(8'h55);
`endif
      repeat (BURST_LEN) exp_q.push_back(word_q.pop_front());
    end
  endtask

  task automatic checkStream(input string tag);
    checkOutput({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), int'(rx_q[i]), int'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic pulseRdDone();
    rd_done = 1'b1;
    @(negedge sys_clk);
    rd_done = 1'b0;
  endtask

  task automatic waitStarts(input int target, input int budget);
    int n = 0;
    while (starts < target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("starts_reached", int'(starts >= target), 1);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (rsp_busy !== 1'b0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("idle_reached", int'(rsp_busy === 1'b0), 1);
  endtask

  initial begin
    int base_s, base_p, d;

    @(negedge sys_clk);
    checkOutput("rst_rsp_busy", int'(rsp_busy), 0);
    checkOutput("rst_tx_data", int'(tx_data), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);
    checkOutput("idle_rd_en", int'(rfifo_rd_en), 0);
    checkOutput("idle_tx_start", int'(tx_start), 0);
    checkOutput("idle_tx_data", int'(tx_data), 0);
    checkOutput("idle_rsp_busy", int'(rsp_busy), 0);
    checkOutput("idle_pops", pops, 0);
    checkOutput("idle_starts", starts, 0);

    $display("[TB] single burst 11,22,33,44");
    tx_time = 10;
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
    expectBursts(1);
    repeat (2) @(negedge sys_clk);
    base_s = starts; base_p = pops;
    pulseRdDone();
`ifndef RSP_HEADER_EN
    checkOutput("lat_rd_en_c1", int'(rfifo_rd_en), 1);
    @(negedge sys_clk);
    checkOutput("lat_rd_en_c2", int'(rfifo_rd_en), 0);
    @(negedge sys_clk);
    checkOutput("lat_tx_start_c3", int'(tx_start), 1);
`endif
    waitStarts(base_s + BPB, 200);
    waitIdle(100);
    checkOutput("busy_after_tx", int'(tx_busy), 0);
    checkOutput("b1_pops", pops - base_p, BURST_LEN);
    checkOutput("b1_starts", starts - base_s, BPB);
    checkStream("b1");

    $display("[TB] rfifo empty for 15 cycles after rd_done");
    base_s = starts; base_p = pops;
    pulseRdDone();
    repeat (15) @(negedge sys_clk);
    checkOutput("empty_no_pop", pops - base_p, 0);
    checkOutput("empty_rsp_busy", int'(rsp_busy), 1);
    for (int i = 0; i < BURST_LEN; i++) applyStimulus(8'($urandom));
    expectBursts(1);
    waitStarts(base_s + BPB, 200);
    waitIdle(100);
    checkOutput("empty_pops", pops - base_p, BURST_LEN);
    checkStream("empty");

    $display("[TB] pending request and dropped third request");
    tx_time = 6;
    for (int i = 0; i < 2 * BURST_LEN; i++) applyStimulus(8'($urandom));
    expectBursts(2);
    base_s = starts; base_p = pops;
    pulseRdDone();
    waitStarts(base_s + HDR_BYTES + 2, 100);
    pulseRdDone();
    repeat (3) @(negedge sys_clk);
    pulseRdDone();
    waitStarts(base_s + 2 * BPB, 400);
    waitIdle(100);
    repeat (30) @(negedge sys_clk);
    checkOutput("pend_starts", starts - base_s, 2 * BPB);
    checkOutput("pend_pops", pops - base_p, 2 * BURST_LEN);
    checkOutput("pend_rsp_busy", int'(rsp_busy), 0);
    checkStream("pend");

    $display("[TB] reset mid-burst");
    tx_time = 8;
    for (int i = 0; i < BURST_LEN; i++) applyStimulus(8'($urandom));
    expectBursts(1);
    while (exp_q.size() > HDR_BYTES + 2) void'(exp_q.pop_back());
    base_s = starts; base_p = pops;
    pulseRdDone();
    waitStarts(base_s + HDR_BYTES + 2, 100);
    hold_chk = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    checkOutput("abort_rd_en", int'(rfifo_rd_en), 0);
    checkOutput("abort_tx_start", int'(tx_start), 0);
    checkOutput("abort_tx_data", int'(tx_data), 0);
    checkOutput("abort_rsp_busy", int'(rsp_busy), 0);
    sys_rst = 1'b0;
    repeat (40) @(negedge sys_clk);
    checkOutput("abort_pops", pops - base_p, 2);
    checkOutput("abort_starts", starts - base_s, HDR_BYTES + 2);
    checkStream("abort");
    fifo_q.delete();
    word_q.delete();
    repeat (3) @(negedge sys_clk);
    hold_chk = 1'b1;

    $display("[TB] burst AA,BB,CC,DD");
    tx_time = 5;
    applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC); applyStimulus(8'hDD);
    expectBursts(1);
    repeat (2) @(negedge sys_clk);
    base_s = starts; base_p = pops;
    pulseRdDone();
`ifdef RSP_HEADER_EN
    d = 0;
    while (pops == base_p && d < 100) begin
      @(negedge sys_clk);
      d++;
    end
    checkOutput("hdr_before_pop", starts - base_s, 1);
    checkOutput("hdr_tx_idle_at_pop", int'(tx_busy), 0);
`endif
    waitStarts(base_s + BPB, 200);
    waitIdle(100);
    checkStream("aabb");

    $display("[TB] randomized bursts");
    for (int it = 0; it < 6; it++) begin
      tx_time = $urandom_range(1, 12);
      d = $urandom_range(0, 6);
      base_s = starts; base_p = pops;
      pulseRdDone();
      repeat (d) @(negedge sys_clk);
      for (int i = 0; i < BURST_LEN; i++) applyStimulus(8'($urandom));
      expectBursts(1);
      waitStarts(base_s + BPB, 300);
      waitIdle(100);
      checkOutput($sformatf("rnd%0d_pops", it), pops - base_p, BURST_LEN);
      checkStream($sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
